// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: merges 1-cycle ALU results with buffered
// load returns and tracks outstanding loads per destination register.
module writeback_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [RA_W-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_issue,
  input  logic [RA_W-1:0] ld_issue_rd,
  input  logic            ld_valid,
  input  logic [RA_W-1:0] ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic [RA_W-1:0] chk_rs1,
  input  logic [RA_W-1:0] chk_rs2,
  output logic            hazard,
  output logic            RegWrite,
  output logic [RA_W-1:0] Rd,
  output logic [XLEN-1:0] Write_data
);

  localparam int unsigned NREG = 1 << RA_W;
  localparam int unsigned PW   = $clog2(LQ_DEPTH);
  localparam int unsigned CW   = $clog2(LQ_DEPTH + 1);

  logic [RA_W-1:0] fifo_rd_q   [LQ_DEPTH];
  logic [XLEN-1:0] fifo_data_q [LQ_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [NREG-1:0] pend_q, pend_d;
  logic            we_q, we_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;

  logic full, empty, push, pop, sel_alu;

  // Every decision uses start-of-cycle occupancy, so a full FIFO refuses a
  // push even in the cycle it pops, and a fresh push is never popped at once.
  always_comb begin
    full      = (count_q == CW'(LQ_DEPTH));
    empty     = (count_q == '0);
    ld_ready  = !full;
    alu_ready = !full;
    push      = ld_valid && !full;
    pop       = full || (!alu_valid && !empty);
    sel_alu   = !full && alu_valid;
    hazard    = pend_q[chk_rs1] | pend_q[chk_rs2];
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pend_d   = pend_q;
    we_d     = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      we_d     = (fifo_rd_q[rd_ptr_q] != '0);
      rd_d     = fifo_rd_q[rd_ptr_q];
      data_d   = fifo_data_q[rd_ptr_q];
      pend_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
    end else if (sel_alu) begin
      we_d   = (alu_rd != '0);
      rd_d   = alu_rd;
      data_d = alu_data;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
    // Issue is applied after the pop clear so a same-cycle re-issue keeps the bit.
    if (ld_issue && ld_issue_rd != '0) begin
      pend_d[ld_issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_rd_q[wr_ptr_q]   <= ld_rd;
      fifo_data_q[wr_ptr_q] <= ld_data;
    end
  end

  assign RegWrite   = we_q;
  assign Rd         = rd_q;
  assign Write_data = data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic, all
// checked against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RA_W     = 5;
  localparam int unsigned LQ_DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic [RA_W-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            ld_issue;
  logic [RA_W-1:0] ld_issue_rd;
  logic            ld_valid;
  logic [RA_W-1:0] ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;
  logic [RA_W-1:0] chk_rs1, chk_rs2;
  logic            hazard;
  logic            RegWrite;
  logic [RA_W-1:0] Rd;
  logic [XLEN-1:0] Write_data;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(.XLEN(XLEN), .RA_W(RA_W), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
    .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data)
  );

  // Reference model: load FIFO as a queue, scoreboard as a plain bit vector.
  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_issue = 0; ld_issue_rd = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model with
  // the current inputs, then check the registered outputs after the edge.
  task automatic cycle();
    bit   full, do_pop;
    ent_t e;
    @(negedge clk);
    full = (mq.size() == LQ_DEPTH);
    chk("alu_ready", alu_ready, !full);
    chk("ld_ready", ld_ready, !full);
    chk("hazard", hazard, m_pend[chk_rs1] | m_pend[chk_rs2]);
    if (reset) begin
      mq.delete();
      m_pend = '0; m_we = 0; m_rd = '0; m_wd = '0;
    end else begin
      do_pop = full || (!alu_valid && mq.size() > 0);
      if (do_pop) begin
        e = mq.pop_front();
        m_we = (e.rd != 0); m_rd = e.rd; m_wd = e.data;
        m_pend[e.rd] = 1'b0;
      end else if (alu_valid) begin
        m_we = (alu_rd != 0); m_rd = alu_rd; m_wd = alu_data;
      end else begin
        m_we = 0;
      end
      if (ld_valid && !full) mq.push_back('{rd: ld_rd, data: ld_data});
      if (ld_issue && ld_issue_rd != 0) m_pend[ld_issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("RegWrite", RegWrite, m_we);
    chk("Rd", Rd, m_rd);
    chk("Write_data", Write_data, m_wd);
  endtask

  initial begin
    idle_inputs();
    chk_rs1 = '0; chk_rs2 = '0;
    m_pend = '0; m_we = 0; m_rd = '0; m_wd = '0;
    reset = 1;
    @(posedge clk); #1;
    cycle();
    reset = 0;

    // Single ALU write, then idle.
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h1234;
    cycle();
    chk("alu7_we", RegWrite, 1); chk("alu7_rd", Rd, 7); chk("alu7_wd", Write_data, 32'h1234);
    idle_inputs();
    cycle();
    chk("alu7_off", RegWrite, 0);

    // Load issue/return to x3; write 2 clocks after return.
    ld_issue = 1; ld_issue_rd = 5'd3; chk_rs2 = 5'd3;
    cycle();
    idle_inputs();
    chk("haz3_pend", hazard, 1);
    ld_valid = 1; ld_rd = 5'd3; ld_data = 32'hDEAD;
    cycle();
    idle_inputs();
    chk("haz3_buf", hazard, 1);
    chk("ld3_early", RegWrite, 0);
    cycle();
    chk("ld3_we", RegWrite, 1); chk("ld3_rd", Rd, 3); chk("ld3_wd", Write_data, 32'hDEAD);
    chk("haz3_clr", hazard, 0);
    chk_rs2 = '0;

    // ALU held high while two loads return: full FIFO steals one slot.
    alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hA0;
    ld_valid = 1; ld_rd = 5'd8; ld_data = 32'h88;
    cycle();
    ld_rd = 5'd9; ld_data = 32'h99; alu_data = 32'hA1;
    cycle();
    ld_valid = 0; alu_data = 32'hA2;
    chk("full_alu_rdy", alu_ready, 0);
    cycle();
    chk("full_pop_rd", Rd, 8);
    chk("after_full_ldrdy", ld_ready, 1);
    alu_data = 32'hA3;
    cycle();
    chk("alu_resume", Rd, 10);
    idle_inputs();
    cycle();
    chk("drain9", Rd, 9);

    // x0 destinations are consumed without a write.
    alu_valid = 1; alu_rd = '0; alu_data = 32'hFFFF;
    ld_valid = 1; ld_rd = '0; ld_data = 32'h5555;
    cycle();
    chk("x0_alu", RegWrite, 0);
    idle_inputs();
    cycle();
    chk("x0_ld", RegWrite, 0);
    chk("x0_empty", ld_ready, 1);

    // Re-issue to x4 in the cycle its earlier load pops: set wins.
    ld_issue = 1; ld_issue_rd = 5'd4; chk_rs1 = 5'd4;
    cycle();
    ld_issue = 0; ld_valid = 1; ld_rd = 5'd4; ld_data = 32'h44;
    cycle();
    ld_valid = 0; ld_issue = 1; ld_issue_rd = 5'd4;
    cycle();
    idle_inputs();
    chk("reissue_we", RegWrite, 1);
    chk("reissue_haz", hazard, 1);

    // Reset with a full FIFO and pend[5] set.
    ld_issue = 1; ld_issue_rd = 5'd5; alu_valid = 1; alu_rd = 5'd1;
    ld_valid = 1; ld_rd = 5'd5; ld_data = 32'h50;
    cycle();
    ld_issue = 0; ld_rd = 5'd6;
    cycle();
    chk_rs1 = 5'd5;
    chk("pre_rst_full", ld_ready, 0);
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;
    chk("rst_we", RegWrite, 0); chk("rst_ldrdy", ld_ready, 1); chk("rst_haz", hazard, 0);
    chk("rst_rd", Rd, 0); chk("rst_wd", Write_data, 0);
    m_pend[4] = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      alu_valid   = ($urandom_range(0, 99) < 45);
      alu_rd      = RA_W'($urandom_range(0, 31));
      alu_data    = $urandom;
      ld_issue    = ($urandom_range(0, 99) < 40);
      ld_issue_rd = RA_W'($urandom_range(0, 31));
      ld_valid    = ($urandom_range(0, 99) < 50);
      ld_rd       = ($urandom_range(0, 9) == 0) ? '0 : RA_W'($urandom_range(0, 31));
      ld_data     = $urandom;
      chk_rs1     = RA_W'($urandom_range(0, 31));
      chk_rs2     = RA_W'($urandom_range(0, 31));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-side initiator for the core's register file.
- Merges single-cycle ALU results and variable-latency load results onto the register file's single write port (Rd / Write_data / RegWrite).
- Buffers load returns in a small FIFO.
- Keeps a per-register pending-load scoreboard so decode can stall on load-use hazards.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width (32 registers)
- LQ_DEPTH, 2, load-return FIFO depth (power of 2, >=2)

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result presented this cycle
- alu_rd  in  RA_W  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- ld_issue  in  1  load issued to memory this cycle
- ld_issue_rd  in  RA_W  destination of issued load
- ld_valid  in  1  load data returning
- ld_rd  in  RA_W  destination of returning load
- ld_data  in  XLEN  returned load data
- ld_ready  out  1  FIFO can accept a load return
- chk_rs1  in  RA_W  decode source 1
- chk_rs2  in  RA_W  decode source 2
- hazard  out  1  a checked source has a pending load (combinational)
- RegWrite  out  1  register file write enable (registered)
- Rd  out  RA_W  register file write address (registered)
- Write_data  out  XLEN  register file write data (registered)

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - RegWrite=0, Rd=0, Write_data=0.
  - FIFO empty: count=0, rd/wr pointers=0.
  - All scoreboard bits cleared.
  - Reset overrides every simultaneous input. A load in flight at reset is lost and its pending bit is cleared.
- Load FIFO:
  - Push when ld_valid && ld_ready.
  - ld_ready = (count != LQ_DEPTH), based on start-of-cycle count. No push is allowed into a full FIFO, even if it pops that cycle.
  - A pushed entry is not eligible for output until the next cycle, so minimum load-return-to-write latency is 2 clocks.
- Arbitration, evaluated each cycle on start-of-cycle FIFO state:
  - FIFO full: pop head to output, alu_ready=0.
  - Else alu_valid=1: ALU wins, alu_ready=1, no pop.
  - Else FIFO non-empty: pop head.
  - Else: idle.
  - alu_ready=1 whenever the FIFO is not full, including when alu_valid=0.
  - Simultaneous push and pop with count unchanged is legal; pointers wrap modulo LQ_DEPTH.
- Output register:
  - When a source is selected, next cycle Rd/Write_data = selected rd/data and RegWrite = (rd != 0).
  - Otherwise RegWrite=0 and Rd/Write_data hold their last values.
  - Writes to x0 are consumed and dropped: RegWrite stays 0, but the slot and FIFO entry are still used.
  - ALU latency is 1 clock, accepted cycle to RegWrite.
- Scoreboard (32 bits, bit 0 hardwired 0):
  - Set bit[ld_issue_rd] on ld_issue when ld_issue_rd != 0.
  - Clear bit[rd] in the cycle a load entry is popped.
  - Set and clear of the same bit in the same cycle: set wins.
  - hazard = pend[chk_rs1] | pend[chk_rs2] on current register state. x0 never hazards.
  - A bit cleared on pop is already clear when the write is visible on RegWrite, so a dependent instruction reading one cycle later sees correct data.
- Ordering:
  - ALU results never overtake buffered loads to the same register; decode guarantees this via hazard.
  - If this rule is violated, the block still writes in arbitration order; no checking is performed.

Test Plan:
- Reset with FIFO holding 2 entries and pend[5]=1 -> next cycle RegWrite=0, ld_ready=1, hazard=0 for chk_rs1=5.
- alu_valid=1, alu_rd=7, alu_data=0x1234 for 1 cycle, FIFO empty -> next cycle RegWrite=1, Rd=7, Write_data=0x1234; the cycle after, RegWrite=0.
- ld_issue rd=3, then ld_valid rd=3 data=0xDEAD with no ALU traffic -> hazard=1 for chk_rs2=3 until the pop cycle; RegWrite=1, Rd=3, Write_data=0xDEAD exactly 2 cycles after ld_valid.
- alu_valid held high while two loads return (rd=8, rd=9) -> ALU wins until FIFO full; then alu_ready=0 for one cycle and rd=8 is written; one cycle later ld_ready=1 again and ALU resumes; rd=9 drains on first ALU-idle or full cycle.
- alu_rd=0 with data=0xFFFF, and load return to rd=0 -> RegWrite never asserts; FIFO count returns to 0.
- ld_issue rd=4 in the same cycle a load to rd=4 is popped -> pend[4] remains 1 and hazard stays 1 for chk_rs1=4.
